// File: rtl/rs_station.sv
// rs_station: reservation station for one functional-unit class.
// Holds DEPTH entries; each captures its two operands either as a value
// (tag == NONE_TAG) or as the tag of the unit that will produce it. The CDB
// is snooped every cycle to fill in pending operands. Entries whose operands
// are both present are presented to the functional unit on a valid/ready
// handshake. Entry i owns tag TAG_BASE+i.
//
// Optional feature (macro RS_AGE_ORDER_EN): per-entry age counters. Dispatch
// then picks the oldest ready entry, and the pick is locked until the
// handshake completes. Without the macro, dispatch picks the lowest-index
// ready entry.
//
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   issue_valid/issue_ready        issue handshake
//   issue_op, issue_tag1/2, issue_val1/2   instruction being issued
//   alloc_tag                      tag of the entry that would be allocated
//   cdb_valid, cdb_tag, cdb_val    common data bus broadcast
//   disp_valid/disp_ready          dispatch handshake
//   disp_op, disp_a, disp_b, disp_tag      presented entry
module rs_station #(
  parameter int DEPTH     = 4,
  parameter int TAG_BASE  = 0,
  parameter int UNIT_SIZE = 8,
  parameter int WORD_SIZE = 32,
  parameter int OP_W      = 4,
  parameter logic [UNIT_SIZE-1:0] NONE_TAG = 'h7F
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 issue_valid,
  output logic                 issue_ready,
  input  logic [OP_W-1:0]      issue_op,
  input  logic [UNIT_SIZE-1:0] issue_tag1,
  input  logic [WORD_SIZE-1:0] issue_val1,
  input  logic [UNIT_SIZE-1:0] issue_tag2,
  input  logic [WORD_SIZE-1:0] issue_val2,
  output logic [UNIT_SIZE-1:0] alloc_tag,
  input  logic                 cdb_valid,
  input  logic [UNIT_SIZE-1:0] cdb_tag,
  input  logic [WORD_SIZE-1:0] cdb_val,
  output logic                 disp_valid,
  input  logic                 disp_ready,
  output logic [OP_W-1:0]      disp_op,
  output logic [WORD_SIZE-1:0] disp_a,
  output logic [WORD_SIZE-1:0] disp_b,
  output logic [UNIT_SIZE-1:0] disp_tag
);

  localparam int IW = $clog2(DEPTH);

  logic [DEPTH-1:0]     busy;
  logic [OP_W-1:0]      op_q   [DEPTH];
  logic [UNIT_SIZE-1:0] tag1_q [DEPTH];
  logic [WORD_SIZE-1:0] val1_q [DEPTH];
  logic [UNIT_SIZE-1:0] tag2_q [DEPTH];
  logic [WORD_SIZE-1:0] val2_q [DEPTH];

  logic [DEPTH-1:0] ready;
  logic             free_found;
  logic [IW-1:0]    free_idx;
  logic             sel_found;
  logic [IW-1:0]    sel_idx;
  logic             cdb_hit;
  logic             issue_fire;
  logic             disp_fire;

`ifdef RS_AGE_ORDER_EN
  logic [IW-1:0] age_q [DEPTH];
  logic          lock_q;
  logic [IW-1:0] lock_idx_q;
  logic [IW-1:0] best_age;
`endif

  assign cdb_hit = cdb_valid && (cdb_tag != NONE_TAG);

  always_comb begin
    for (int i = 0; i < DEPTH; i++)
      ready[i] = busy[i] && (tag1_q[i] == NONE_TAG) && (tag2_q[i] == NONE_TAG);
  end

  // Lowest free entry; scanning downward leaves the lowest index last.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
    end
  end

  // issue_ready is forced low during reset even though every entry is free.
  assign issue_ready = rst_n && free_found;
  assign alloc_tag   = UNIT_SIZE'(TAG_BASE) + UNIT_SIZE'(free_idx);
  assign issue_fire  = issue_valid && issue_ready;

`ifdef RS_AGE_ORDER_EN
  // Oldest ready entry; strict '>' keeps ties on the lowest index.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    best_age  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ready[i] && (!sel_found || age_q[i] > best_age)) begin
        sel_found = 1'b1;
        sel_idx   = IW'(i);
        best_age  = age_q[i];
      end
    end
    if (lock_q) begin
      sel_found = 1'b1;
      sel_idx   = lock_idx_q;
    end
  end
`else
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ready[i]) begin
        sel_found = 1'b1;
        sel_idx   = IW'(i);
      end
    end
  end
`endif

  assign disp_valid = sel_found;
  assign disp_fire  = disp_valid && disp_ready;
  assign disp_op    = sel_found ? op_q[sel_idx]   : '0;
  assign disp_a     = sel_found ? val1_q[sel_idx] : '0;
  assign disp_b     = sel_found ? val2_q[sel_idx] : '0;
  assign disp_tag   = sel_found ? UNIT_SIZE'(TAG_BASE) + UNIT_SIZE'(sel_idx) : NONE_TAG;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i]   <= '0;
        tag1_q[i] <= NONE_TAG;
        val1_q[i] <= '0;
        tag2_q[i] <= NONE_TAG;
        val2_q[i] <= '0;
`ifdef RS_AGE_ORDER_EN
        age_q[i]  <= '0;
`endif
      end
`ifdef RS_AGE_ORDER_EN
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
`endif
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (cdb_hit && busy[i] && tag1_q[i] == cdb_tag) begin
          tag1_q[i] <= NONE_TAG;
          val1_q[i] <= cdb_val;
        end
        if (cdb_hit && busy[i] && tag2_q[i] == cdb_tag) begin
          tag2_q[i] <= NONE_TAG;
          val2_q[i] <= cdb_val;
        end
`ifdef RS_AGE_ORDER_EN
        if (issue_fire && busy[i] && age_q[i] != {IW{1'b1}})
          age_q[i] <= age_q[i] + 1'b1;
`endif
      end

      // The dispatched entry is busy and the allocated one is free, so these
      // never target the same entry.
      if (disp_fire)
        busy[sel_idx] <= 1'b0;

      if (issue_fire) begin
        busy[free_idx] <= 1'b1;
        op_q[free_idx] <= issue_op;
        // Bypass a broadcast that lands in the same cycle as the issue.
        if (cdb_hit && cdb_tag == issue_tag1) begin
          tag1_q[free_idx] <= NONE_TAG;
          val1_q[free_idx] <= cdb_val;
        end else begin
          tag1_q[free_idx] <= issue_tag1;
          val1_q[free_idx] <= issue_val1;
        end
        if (cdb_hit && cdb_tag == issue_tag2) begin
          tag2_q[free_idx] <= NONE_TAG;
          val2_q[free_idx] <= cdb_val;
        end else begin
          tag2_q[free_idx] <= issue_tag2;
          val2_q[free_idx] <= issue_val2;
        end
`ifdef RS_AGE_ORDER_EN
        age_q[free_idx] <= '0;
`endif
      end

`ifdef RS_AGE_ORDER_EN
      lock_q     <= disp_valid && !disp_ready;
      lock_idx_q <= sel_idx;
`endif
    end
  end

endmodule
